// File: rtl/nes_ctrl_reader_if.sv
// Signal bundle between the NES pad reader and its surroundings: the
// enable/pad-data inputs, the pad latch/pulse pins and the button report.
// The reader uses the master view, the pad/system side uses the slave view.
interface nes_ctrl_reader_if;
    logic       enable;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] nes_buttons;
    logic       buttons_valid;
    logic       busy;

    modport master (
        input  enable,
        input  nes_data,
        output nes_latch,
        output nes_pulse,
        output nes_buttons,
        output buttons_valid,
        output busy
    );

    modport slave (
        output enable,
        output nes_data,
        input  nes_latch,
        input  nes_pulse,
        input  nes_buttons,
        input  buttons_valid,
        input  busy
    );
endinterface

// File: rtl/nes_ctrl_reader.sv
// NES gamepad reader: polls one pad over latch/pulse/data at POLL_CYCLES
// intervals and reports an active-high 8-bit button vector with a one-cycle
// update strobe. Optional feature macro: NES_DEBOUNCE_EN (a button bit only
// changes when two consecutive transactions sampled the same value).
module nes_ctrl_reader #(
    parameter int unsigned HALF_CYCLES  = 600,
    parameter int unsigned LATCH_CYCLES = 1200,
    parameter int unsigned POLL_CYCLES  = 1666667
) (
    input  logic                 sysclk,
    input  logic                 sysreset,
    nes_ctrl_reader_if.master    bus
);

    localparam int unsigned CNT_W  = $clog2(LATCH_CYCLES + HALF_CYCLES + 1);
    localparam int unsigned POLL_W = $clog2(POLL_CYCLES + 1);

    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_GAP   = 3'd2,
        S_PHI   = 3'd3,
        S_PLO   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              pending_q, pending_d;
    logic [POLL_W-1:0] poll_q;
    logic              sync1_q, sync2_q;
    logic              latch_q, pulse_q, valid_q, busy_q;
    logic [7:0]        buttons_q, buttons_d;
    logic              poll_tick_s;
    logic              sample_s;
    logic              start_s;

`ifdef NES_DEBOUNCE_EN
    logic [7:0]        prev_q, prev_d;

    // Keep the previously reported value of every bit whose last two samples disagree.
    function automatic logic [7:0] debounce_merge(input logic [7:0] cur,
                                                  input logic [7:0] prev,
                                                  input logic [7:0] held);
        logic [7:0] agree;
        agree = ~(cur ^ prev);
        return (cur & agree) | (held & ~agree);
    endfunction
`endif

    // Pad bit after synchronisation; the pad drives 0 for a pressed button.
    assign sample_s    = ~sync2_q;
    assign poll_tick_s = bus.enable && (poll_q == POLL_LAST);
    assign start_s     = (state_q == S_IDLE) && bus.enable && (poll_tick_s || pending_q);

    // Two-flop synchroniser for the asynchronous pad data line (idle = released).
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.nes_data;
            sync2_q <= sync1_q;
        end
    end

    // Free-running poll period counter, parked at zero while polling is disabled.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            poll_q <= '0;
        end else if (!bus.enable) begin
            poll_q <= '0;
        end else if (poll_q == POLL_LAST) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_q + POLL_W'(1);
        end
    end

    // Transaction sequencing: next state, phase counter, bit index and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_s) begin
                    state_d = S_LATCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    state_d = S_LATCH;
                end
            end
            S_GAP: begin
                if (cnt_q == HALF_LAST) begin
                    shift_d[0] = sample_s;
                    idx_d      = 3'd1;
                    state_d    = S_PHI;
                    cnt_d      = '0;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_PHI: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_PLO;
                    cnt_d   = '0;
                end else begin
                    state_d = S_PHI;
                end
            end
            S_PLO: begin
                if (cnt_q == HALF_LAST) begin
                    shift_d[idx_q] = sample_s;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_PHI;
                    end
                end else begin
                    state_d = S_PLO;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending request: remembers a poll tick that arrived while a transaction was running.
    always_comb begin
        pending_d = pending_q;
        if (!bus.enable) begin
            pending_d = 1'b0;
        end else if (poll_tick_s && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end else if (start_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Button report: whole-vector update on entry to DONE, optionally debounced.
    always_comb begin
        buttons_d = buttons_q;
`ifdef NES_DEBOUNCE_EN
        prev_d = prev_q;
        if (state_d == S_DONE) begin
            buttons_d = debounce_merge(shift_d, prev_q, buttons_q);
            prev_d    = shift_d;
        end else begin
            buttons_d = buttons_q;
            prev_d    = prev_q;
        end
`else
        if (state_d == S_DONE) begin
            buttons_d = shift_d;
        end else begin
            buttons_d = buttons_q;
        end
`endif
    end

    // State, counters and pending flag.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            pending_q <= pending_d;
        end
    end

    // Registered outputs decoded from the next state so they line up with state_q.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            buttons_q <= 8'h00;
        end else begin
            latch_q   <= (state_d == S_LATCH);
            pulse_q   <= (state_d == S_PHI);
            valid_q   <= (state_d == S_DONE);
            busy_q    <= (state_d != S_IDLE);
            buttons_q <= buttons_d;
        end
    end

`ifdef NES_DEBOUNCE_EN
    // Samples of the previous transaction, compared bit-wise at the next DONE.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            prev_q <= 8'h00;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

    assign bus.nes_latch     = latch_q;
    assign bus.nes_pulse     = pulse_q;
    assign bus.buttons_valid = valid_q;
    assign bus.busy          = busy_q;
    assign bus.nes_buttons   = buttons_q;

endmodule
